// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and default widths for the fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int A_DEF    = 10;
    localparam int OFFW_DEF = 8;
    localparam int CW_DEF   = 16;

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - next-PC selection: increment, absolute or relative branch, wrapping mod 2**A
module pc_next_calc
    import fetch_pkg::*;
#(
    parameter int A    = A_DEF,
    parameter int OFFW = OFFW_DEF
) (
    input  logic [A-1:0]    pc,
    input  logic            branch_en,
    input  logic            branch_abs,
    input  logic [A-1:0]    branch_target,
    input  logic [OFFW-1:0] branch_offset,
    output logic [A-1:0]    next_pc
);

    // Sign-extend (or truncate) the offset to PC width; the add then wraps naturally.
    logic [A-1:0] off_ext;
    assign off_ext = A'($signed(branch_offset));

    always_comb begin
        next_pc = pc + A'(1);
        if (branch_en) begin
            next_pc = branch_abs ? branch_target : (pc + off_ext);
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - program-counter sequencer with run/halt handshake and saturating cycle counter
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int A    = A_DEF,
    parameter int OFFW = OFFW_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Start,
    input  logic [A-1:0]    StartAddr,
    input  logic            Ack,
    input  logic            Stall,
    input  logic            Halt,
    input  logic            BranchEn,
    input  logic            BranchAbs,
    input  logic [A-1:0]    BranchTarget,
    input  logic [OFFW-1:0] BranchOffset,
    output logic [A-1:0]    InstAddress,
    output logic            InstValid,
    output logic            Busy,
    output logic            Done,
    output logic [CW-1:0]   CycleCount
);

    fetch_state_t  state;
    logic [A-1:0]  pc;
    logic [A-1:0]  next_pc;
    logic [CW-1:0] cycle_count;

    pc_next_calc #(.A(A), .OFFW(OFFW)) u_pc_next_calc (
        .pc            (pc),
        .branch_en     (BranchEn),
        .branch_abs    (BranchAbs),
        .branch_target (BranchTarget),
        .branch_offset (BranchOffset),
        .next_pc       (next_pc)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            pc          <= '0;
            cycle_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        pc          <= StartAddr;
                        cycle_count <= '0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CW'(1);
                    end
                    // Stall outranks Halt and branches; Halt leaves PC on the halt instruction.
                    if (Stall) begin
                        pc <= pc;
                    end else if (Halt) begin
                        state <= HALTED;
                    end else begin
                        pc <= next_pc;
                    end
                end
                HALTED: begin
                    if (Ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign InstAddress = pc;
    assign CycleCount  = cycle_count;
    assign InstValid   = (state == RUN);
    assign Busy        = (state == RUN);
    assign Done        = (state == HALTED);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - directed self-checking bench for inst_fetch_ctrl
module tb_inst_fetch_ctrl;

    logic       Clk;
    logic       Reset_n;
    logic       Start, Ack, Stall, Halt, BranchEn, BranchAbs;
    logic [9:0] StartAddr, BranchTarget;
    logic [7:0] BranchOffset;
    logic [9:0] InstAddress;
    logic       InstValid, Busy, Done;
    logic [15:0] CycleCount;

    logic       s4_start, s4_ack, s4_stall, s4_halt, s4_ben, s4_babs;
    logic [9:0] s4_saddr, s4_btgt;
    logic [7:0] s4_boff;
    logic [9:0] s4_addr;
    logic       s4_valid, s4_busy, s4_done;
    logic [3:0] s4_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    inst_fetch_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
        .Ack(Ack), .Stall(Stall), .Halt(Halt), .BranchEn(BranchEn),
        .BranchAbs(BranchAbs), .BranchTarget(BranchTarget), .BranchOffset(BranchOffset),
        .InstAddress(InstAddress), .InstValid(InstValid), .Busy(Busy), .Done(Done),
        .CycleCount(CycleCount)
    );

    inst_fetch_ctrl #(.A(10), .OFFW(8), .CW(4)) dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(s4_start), .StartAddr(s4_saddr),
        .Ack(s4_ack), .Stall(s4_stall), .Halt(s4_halt), .BranchEn(s4_ben),
        .BranchAbs(s4_babs), .BranchTarget(s4_btgt), .BranchOffset(s4_boff),
        .InstAddress(s4_addr), .InstValid(s4_valid), .Busy(s4_busy), .Done(s4_done),
        .CycleCount(s4_count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_step();
        step();
        exp_cnt++;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        Start = 0; Ack = 0; Stall = 0; Halt = 0; BranchEn = 0; BranchAbs = 0;
        StartAddr = '0; BranchTarget = '0; BranchOffset = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        s4_start = 0; s4_ack = 0; s4_stall = 0; s4_halt = 0; s4_ben = 0; s4_babs = 0;
        s4_saddr = '0; s4_btgt = '0; s4_boff = '0;
        Reset_n = 0;
        #12;
        chk("reset_pc", 16'(InstAddress), 16'd0);
        chk("reset_busy", 16'(Busy), 16'd0);
        chk("reset_valid", 16'(InstValid), 16'd0);
        chk("reset_done", 16'(Done), 16'd0);
        chk("reset_count", CycleCount, 16'd0);
        Reset_n = 1;
        step();
        chk("idle_hold_pc", 16'(InstAddress), 16'd0);
    endtask

    task automatic test_start_sequence();
        StartAddr = 10'd5; Start = 1;
        step(); exp_cnt = 0;
        Start = 0;
        chk("start_pc0", 16'(InstAddress), 16'd5);
        chk("start_busy", 16'(Busy), 16'd1);
        chk("start_valid", 16'(InstValid), 16'd1);
        run_step(); chk("seq_pc1", 16'(InstAddress), 16'd6);
        run_step(); chk("seq_pc2", 16'(InstAddress), 16'd7);
    endtask

    task automatic test_branches();
        BranchEn = 1; BranchAbs = 1; BranchTarget = 10'd10;
        run_step(); chk("abs_to_10", 16'(InstAddress), 16'd10);
        BranchAbs = 0; BranchOffset = 8'hFD;
        run_step(); chk("rel_minus3", 16'(InstAddress), 16'd7);
        BranchAbs = 1; BranchTarget = 10'd1000;
        run_step(); chk("abs_to_1000", 16'(InstAddress), 16'd1000);
        BranchTarget = 10'd1022;
        run_step(); chk("abs_to_1022", 16'(InstAddress), 16'd1022);
        BranchAbs = 0; BranchOffset = 8'd5;
        run_step(); chk("rel_wrap_plus5", 16'(InstAddress), 16'd3);
        BranchAbs = 1; BranchTarget = 10'd1023;
        run_step(); chk("abs_to_1023", 16'(InstAddress), 16'd1023);
        BranchEn = 0;
        run_step(); chk("inc_wrap", 16'(InstAddress), 16'd0);
        chk("count_after_branches", CycleCount, 16'(exp_cnt));
    endtask

    task automatic test_stall_halt();
        BranchEn = 1; BranchAbs = 1; BranchTarget = 10'd20;
        run_step();
        BranchEn = 0;
        Stall = 1; Halt = 1;
        for (int i = 0; i < 3; i++) begin
            run_step();
            chk("stall_pc", 16'(InstAddress), 16'd20);
            chk("stall_busy", 16'(Busy), 16'd1);
        end
        chk("stall_count", CycleCount, 16'(exp_cnt));
        Stall = 0;
        run_step();
        Halt = 0;
        chk("halt_done", 16'(Done), 16'd1);
        chk("halt_pc", 16'(InstAddress), 16'd20);
        chk("halt_valid", 16'(InstValid), 16'd0);
        step();
        chk("halted_count_hold", CycleCount, 16'(exp_cnt));
        chk("halted_still_done", 16'(Done), 16'd1);
    endtask

    task automatic test_halt_branch_ack_start();
        Ack = 1;
        step();
        Ack = 0;
        chk("ack_to_idle", 16'(Done), 16'd0);
        StartAddr = 10'd50; Start = 1;
        step(); exp_cnt = 0;
        Start = 0;
        chk("restart_pc", 16'(InstAddress), 16'd50);
        chk("restart_count", CycleCount, 16'd0);
        Halt = 1; BranchEn = 1; BranchAbs = 1; BranchTarget = 10'd99;
        run_step();
        Halt = 0; BranchEn = 0;
        chk("halt_over_branch_done", 16'(Done), 16'd1);
        chk("halt_over_branch_pc", 16'(InstAddress), 16'd50);
        Ack = 1; Start = 1; StartAddr = 10'd7;
        step();
        Ack = 0; Start = 0;
        chk("ack_wins_busy", 16'(Busy), 16'd0);
        chk("ack_wins_done", 16'(Done), 16'd0);
        chk("ack_wins_pc", 16'(InstAddress), 16'd50);
        step();
        chk("no_new_run", 16'(Busy), 16'd0);
        chk("idle_pc_hold", 16'(InstAddress), 16'd50);
    endtask

    task automatic test_async_reset();
        StartAddr = 10'd300; Start = 1;
        step(); exp_cnt = 0;
        Start = 0;
        chk("run300_pc", 16'(InstAddress), 16'd300);
        #1;
        Reset_n = 0;
        #1;
        chk("async_pc", 16'(InstAddress), 16'd0);
        chk("async_busy", 16'(Busy), 16'd0);
        chk("async_done", 16'(Done), 16'd0);
        #1;
        Reset_n = 1;
        StartAddr = 10'd12; Start = 1;
        step(); exp_cnt = 0;
        Start = 0;
        chk("post_reset_pc", 16'(InstAddress), 16'd12);
        run_step();
        chk("post_reset_pc1", 16'(InstAddress), 16'd13);
        chk("post_reset_count", CycleCount, 16'd1);
    endtask

    task automatic test_saturation();
        s4_saddr = 10'd0; s4_start = 1;
        step();
        s4_start = 0;
        chk("sat_start_pc", 16'(s4_addr), 16'd0);
        for (int i = 1; i <= 20; i++) begin
            s4_start = (i % 3 == 0);
            s4_saddr = 10'd500;
            step();
            if (s4_addr !== 10'(i)) begin
                checks++; errors++;
                $display("FAIL sat_seq_pc[%0d]: got %0d expected %0d", i, s4_addr, i);
            end else begin
                checks++;
            end
        end
        s4_start = 0;
        chk("sat_count", 16'(s4_count), 16'd15);
        chk("sat_busy", 16'(s4_busy), 16'd1);
    endtask

    initial begin
        test_reset();
        test_start_sequence();
        test_branches();
        test_stall_halt();
        test_halt_branch_ack_start();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
